// File: rtl/vga_sync_porch.sv
// VGA sync porch stage: turns active-area indicators into porched, active-low sync pulses
// once the input frame timing is verified. Define VGA_SYNC_PORCH_BLANK_EN to blank porch video.
module vga_sync_porch #(
  parameter int unsigned VIDEO_WIDTH      = 3,
  parameter int unsigned TOTAL_COLS       = 800,
  parameter int unsigned TOTAL_ROWS       = 525,
  parameter int unsigned ACTIVE_COLS      = 640,
  parameter int unsigned ACTIVE_ROWS      = 480,
  parameter int unsigned FRONT_PORCH_HORZ = 18,
  parameter int unsigned BACK_PORCH_HORZ  = 50,
  parameter int unsigned FRONT_PORCH_VERT = 10,
  parameter int unsigned BACK_PORCH_VERT  = 33
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked
);

  localparam int unsigned COL_W = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
  localparam int unsigned ROW_W = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;

  localparam int unsigned COL_LAST = TOTAL_COLS - 1;
  localparam int unsigned ROW_LAST = TOTAL_ROWS - 1;
  localparam int unsigned HS_FIRST = ACTIVE_COLS + FRONT_PORCH_HORZ;
  localparam int unsigned HS_LAST  = TOTAL_COLS - BACK_PORCH_HORZ - 1;
  localparam int unsigned VS_FIRST = ACTIVE_ROWS + FRONT_PORCH_VERT;
  localparam int unsigned VS_LAST  = TOTAL_ROWS - BACK_PORCH_VERT - 1;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } state_e;

  state_e state_q, state_d;

  logic             vsync_prev_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [31:0]      col_w, row_w;
  logic             frame_start;
  logic             col_at_last, at_last;

  // Stage 1: input pixel, aligned with the counter position it was assigned.
  logic [VIDEO_WIDTH-1:0] red_s1_q, grn_s1_q, blu_s1_q;

  // Stage 2: registered outputs.
  logic                   hsync_s2_q, vsync_s2_q, locked_s2_q;
  logic [VIDEO_WIDTH-1:0] red_s2_q, grn_s2_q, blu_s2_q;
  logic                   hsync_s2_d, vsync_s2_d, locked_s2_d;
  logic [VIDEO_WIDTH-1:0] red_s2_d, grn_s2_d, blu_s2_d;
  logic                   in_hs_pulse, in_vs_pulse;

  // The active-column indicator carries no information beyond the counters.
  logic unused_hsync;
  assign unused_hsync = i_HSync;

  assign frame_start = i_VSync & ~vsync_prev_q;

  // Zero-extend so every position compare is an unsigned 32-bit compare.
  assign col_w = 32'(col_q);
  assign row_w = 32'(row_q);

  assign col_at_last = (col_w == COL_LAST);
  assign at_last     = col_at_last && (row_w == ROW_LAST);

  // Counters hold the position of the pixel sampled on the previous edge.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (col_at_last) begin
      col_d = '0;
      row_d = (row_w == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  // A frame start is trusted only if it lands exactly where the previous frame predicted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) state_d = StAcquire;
      end
      StAcquire: begin
        if (frame_start) state_d = at_last ? StLocked : StAcquire;
      end
      StLocked: begin
        if (frame_start) begin
          state_d = at_last ? StLocked : StAcquire;
        end else if (at_last) begin
          state_d = StAcquire;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_hs_pulse = (col_w >= HS_FIRST) && (col_w <= HS_LAST);
  assign in_vs_pulse = (row_w >= VS_FIRST) && (row_w <= VS_LAST);

  always_comb begin
    hsync_s2_d  = 1'b1;
    vsync_s2_d  = 1'b1;
    locked_s2_d = 1'b0;
    red_s2_d    = '0;
    grn_s2_d    = '0;
    blu_s2_d    = '0;
    if (state_q == StLocked) begin
      locked_s2_d = 1'b1;
      hsync_s2_d  = ~in_hs_pulse;
      vsync_s2_d  = ~in_vs_pulse;
`ifdef VGA_SYNC_PORCH_BLANK_EN
      if ((col_w < ACTIVE_COLS) && (row_w < ACTIVE_ROWS)) begin
        red_s2_d = red_s1_q;
        grn_s2_d = grn_s1_q;
        blu_s2_d = blu_s1_q;
      end
`else
      red_s2_d = red_s1_q;
      grn_s2_d = grn_s1_q;
      blu_s2_d = blu_s1_q;
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= StIdle;
      vsync_prev_q <= 1'b1;  // forces a genuine low-to-high edge after reset
      col_q        <= '0;
      row_q        <= '0;
      red_s1_q     <= '0;
      grn_s1_q     <= '0;
      blu_s1_q     <= '0;
      hsync_s2_q   <= 1'b1;
      vsync_s2_q   <= 1'b1;
      locked_s2_q  <= 1'b0;
      red_s2_q     <= '0;
      grn_s2_q     <= '0;
      blu_s2_q     <= '0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= i_VSync;
      col_q        <= col_d;
      row_q        <= row_d;
      red_s1_q     <= i_Red_Video;
      grn_s1_q     <= i_Grn_Video;
      blu_s1_q     <= i_Blu_Video;
      hsync_s2_q   <= hsync_s2_d;
      vsync_s2_q   <= vsync_s2_d;
      locked_s2_q  <= locked_s2_d;
      red_s2_q     <= red_s2_d;
      grn_s2_q     <= grn_s2_d;
      blu_s2_q     <= blu_s2_d;
    end
  end

  assign o_HSync     = hsync_s2_q;
  assign o_VSync     = vsync_s2_q;
  assign o_Locked    = locked_s2_q;
  assign o_Red_Video = red_s2_q;
  assign o_Grn_Video = grn_s2_q;
  assign o_Blu_Video = blu_s2_q;

endmodule
